// File: rtl/bram_boot_ctrl.sv
// Boot sequencer: streams words into the data BRAM, then the instruction BRAM, then hands the data port to the CPU.
// Optional BOOT_CHECKSUM_EN adds a trailing checksum word with CHECK/ERROR states.
module bram_boot_ctrl #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-3:0] d_count,
    input  logic [ADDR_WIDTH-3:0] i_count,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    input  logic [ADDR_WIDTH-1:0] cpu_w_addr,
    input  logic [DATA_WIDTH-1:0] cpu_w_dat,
    input  logic                  cpu_w_enb,
    input  logic [3:0]            cpu_byte_enb,
    output logic [ADDR_WIDTH-1:0] i_w_addr,
    output logic [DATA_WIDTH-1:0] i_w_dat,
    output logic                  i_w_enb,
    output logic [3:0]            i_w_byte_enb,
    output logic [ADDR_WIDTH-1:0] d_w_addr,
    output logic [DATA_WIDTH-1:0] d_w_dat,
    output logic                  d_w_enb,
    output logic [3:0]            d_w_byte_enb,
    output logic                  pc_stall,
    output logic                  i_r_enb,
    output logic                  rd_enbl,
    output logic                  init_done,
    output logic                  busy,
    output logic                  err
);
    localparam int IW = ADDR_WIDTH - 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_D = 3'd1,
        LOAD_I = 3'd2,
        RUN    = 3'd3
`ifdef BOOT_CHECKSUM_EN
        , CHECK = 3'd4,
        ERROR  = 3'd5
`endif
    } state_t;

    state_t                state, next_state, start_target, post_load;
    logic                  drain, drain_set;
    logic [IW-1:0]         idx, d_cnt, i_cnt;
    logic                  d_ld_enb, i_ld_enb;
    logic [ADDR_WIDTH-1:0] d_ld_addr, i_ld_addr;
    logic [DATA_WIDTH-1:0] d_ld_dat, i_ld_dat;
    logic                  ready, hs, last, load_done, take_start;
`ifdef BOOT_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum;
`endif

    // Handshake: a word transfers on any edge where s_valid and s_ready are both high.
    always_comb begin
`ifdef BOOT_CHECKSUM_EN
        post_load = CHECK;
        ready     = ((state == LOAD_D || state == LOAD_I) && !drain) || state == CHECK;
`else
        post_load = RUN;
        ready     = (state == LOAD_D || state == LOAD_I) && !drain;
`endif
        if (d_count != '0)      start_target = LOAD_D;
        else if (i_count != '0) start_target = LOAD_I;
        else                    start_target = post_load;
        hs        = s_valid && ready;
        last      = (state == LOAD_D) ? (IW'(idx + 1'b1) == d_cnt) : (IW'(idx + 1'b1) == i_cnt);
        load_done = hs && last && (state == LOAD_I || (state == LOAD_D && i_cnt == '0));
    end

    always_comb begin
        next_state = state;
        drain_set  = 1'b0;
        take_start = 1'b0;
        case (state)
            IDLE, RUN: begin
                if (start) begin
                    take_start = 1'b1;
                    next_state = start_target;
                end
            end
            LOAD_D, LOAD_I: begin
                // Without a checksum, hold one cycle after the last word so its strobe lands before RUN.
                if (drain) begin
                    next_state = RUN;
                end else if (load_done) begin
`ifdef BOOT_CHECKSUM_EN
                    next_state = CHECK;
`else
                    drain_set  = 1'b1;
`endif
                end else if (hs && last) begin
                    next_state = LOAD_I;
                end
            end
`ifdef BOOT_CHECKSUM_EN
            CHECK: begin
                if (hs) next_state = (s_data == sum) ? RUN : ERROR;
            end
            ERROR: begin
                if (start) begin
                    take_start = 1'b1;
                    next_state = start_target;
                end
            end
`endif
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            drain     <= 1'b0;
            idx       <= '0;
            d_cnt     <= '0;
            i_cnt     <= '0;
            d_ld_enb  <= 1'b0;
            i_ld_enb  <= 1'b0;
            d_ld_addr <= '0;
            i_ld_addr <= '0;
            d_ld_dat  <= '0;
            i_ld_dat  <= '0;
`ifdef BOOT_CHECKSUM_EN
            sum       <= '0;
`endif
        end else begin
            state    <= next_state;
            drain    <= drain_set;
            d_ld_enb <= 1'b0;
            i_ld_enb <= 1'b0;
            if (take_start) begin
                d_cnt <= d_count;
                i_cnt <= i_count;
                idx   <= '0;
`ifdef BOOT_CHECKSUM_EN
                sum   <= '0;
`endif
            end
            if (hs && (state == LOAD_D || state == LOAD_I)) begin
                idx <= last ? '0 : idx + 1'b1;
`ifdef BOOT_CHECKSUM_EN
                sum <= sum + s_data;
`endif
            end
            if (hs && state == LOAD_D) begin
                d_ld_enb  <= 1'b1;
                d_ld_addr <= {idx, 2'b00};
                d_ld_dat  <= s_data;
            end
            if (hs && state == LOAD_I) begin
                i_ld_enb  <= 1'b1;
                i_ld_addr <= {idx, 2'b00};
                i_ld_dat  <= s_data;
            end
        end
    end

    always_comb begin
        if (state == RUN) begin
            d_w_addr     = cpu_w_addr;
            d_w_dat      = cpu_w_dat;
            d_w_enb      = cpu_w_enb;
            d_w_byte_enb = cpu_byte_enb;
        end else begin
            d_w_addr     = d_ld_addr;
            d_w_dat      = d_ld_dat;
            d_w_enb      = d_ld_enb;
            d_w_byte_enb = {4{d_ld_enb}};
        end
        i_w_addr     = i_ld_addr;
        i_w_dat      = i_ld_dat;
        i_w_enb      = i_ld_enb && (state != RUN);
        i_w_byte_enb = {4{i_w_enb}};
    end

    assign s_ready   = ready;
    assign pc_stall  = (state != RUN);
    assign i_r_enb   = (state == RUN);
    assign rd_enbl   = (state == RUN);
    assign init_done = (state == RUN);
    assign busy      = (state == LOAD_D) || (state == LOAD_I);
`ifdef BOOT_CHECKSUM_EN
    assign err       = (state == ERROR);
`else
    assign err       = 1'b0;
`endif
endmodule
